// File: rtl/rand_arbiter.sv
// Round-robin distributor for a shared 32-bit uniform random stream.
// Sequences generator start-up (wait, warm-up discard) and latches generator errors.
module rand_arbiter #(
  parameter int NREQ   = 4,
  parameter int WARMUP = 16,
  parameter int DELAY  = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            gen_valid,
  input  logic            gen_error,
  input  logic [31:0]     gen_rand,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rand_out,
  output logic            ready,
  output logic            fault,
  output logic [15:0]     served
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  // DELAY only shaped simulation timing in older models; registers here carry no delay.
  if (NREQ < 2 || NREQ > 16 || DELAY < 0) begin : g_bad_params
    $error("rand_arbiter: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_WAIT, ST_WARM, ST_SERVE, ST_FAULT} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   warm_cnt;
  logic [PW-1:0]   ptr;
  logic            ptr_valid;
  logic [PW-1:0]   pick;
  logic            pick_found;
  logic            grant;
  int              start;
  int              idx;

  // Until the first grant the search begins at index 0 rather than ptr+1.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    start      = ptr_valid ? ((int'(ptr) + 1) % NREQ) : 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick       = PW'(idx);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_WAIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT:  if (gen_valid) state_next = (WARMUP == 0) ? ST_SERVE : ST_WARM;
      ST_WARM:  if (gen_valid && warm_cnt == CW'(WARMUP - 1)) state_next = ST_SERVE;
      ST_SERVE: state_next = ST_SERVE;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_WAIT;
    endcase
    if (gen_error) state_next = ST_FAULT;
  end

  // An error in the same cycle suppresses the grant.
  assign grant = (state == ST_SERVE) && gen_valid && !gen_error && pick_found;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gnt       <= '0;
      rand_out  <= '0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      served    <= '0;
      ptr       <= '0;
      ptr_valid <= 1'b0;
      warm_cnt  <= '0;
    end else begin
      gnt   <= '0;
      ready <= (state_next == ST_SERVE);
      fault <= (state_next == ST_FAULT);
      if (grant) begin
        gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
        rand_out  <= gen_rand;
        ptr       <= pick;
        ptr_valid <= 1'b1;
        served    <= served + 16'd1;
      end
      if (state == ST_WARM && gen_valid) warm_cnt <= warm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed self-checking bench for rand_arbiter (default WARMUP plus a WARMUP=0 instance).
module tb_rand_arbiter;

  logic        clk;
  logic        rst_n;
  logic        gen_valid;
  logic        gen_error;
  logic [31:0] gen_rand;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [31:0] rand_out;
  logic        ready;
  logic        fault;
  logic [15:0] served;
  logic [3:0]  req0;
  logic [3:0]  gnt0;
  logic [31:0] rand_out0;
  logic        ready0;
  logic        fault0;
  logic [15:0] served0;

  int check_count = 0;
  int error_count = 0;

  rand_arbiter #(.NREQ(4), .WARMUP(16), .DELAY(1)) dut (
    .CLK(clk), .RESET_N(rst_n), .gen_valid(gen_valid), .gen_error(gen_error),
    .gen_rand(gen_rand), .req(req), .gnt(gnt), .rand_out(rand_out),
    .ready(ready), .fault(fault), .served(served)
  );

  rand_arbiter #(.NREQ(4), .WARMUP(0), .DELAY(1)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .gen_valid(gen_valid), .gen_error(gen_error),
    .gen_rand(gen_rand), .req(req0), .gnt(gnt0), .rand_out(rand_out0),
    .ready(ready0), .fault(fault0), .served(served0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of generator/request inputs, then sample just after the edge.
  task automatic applyStimulus(input logic valid, input logic err, input logic [31:0] word, input logic [3:0] r);
    gen_valid = valid;
    gen_error = err;
    gen_rand  = word;
    req       = r;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  exp_gnt2 [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0]  exp_gnt3 [4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
  logic [31:0] exp_rnd3 [4] = '{32'h3000_0001, 32'h3000_0001, 32'h3000_0003, 32'h3000_0003};
  logic [15:0] exp_srv3 [4] = '{16'd6, 16'd6, 16'd7, 16'd7};

  initial begin
    rst_n = 1'b0; gen_valid = 1'b0; gen_error = 1'b0; gen_rand = '0; req = '0; req0 = '0;
    #12;
    checkOutput("reset_gnt",      32'(gnt),      32'h0);
    checkOutput("reset_rand_out", rand_out,      32'h0);
    checkOutput("reset_ready",    32'(ready),    32'h0);
    checkOutput("reset_fault",    32'(fault),    32'h0);
    checkOutput("reset_served",   32'(served),   32'h0);
    rst_n = 1'b1;

    // Start-up: two idle cycles, word 1 in WAIT, words 2..17 discarded, word 18 served.
    applyStimulus(1'b0, 1'b0, 32'h0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 32'h0, 4'b0001);
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h1000_0000 + 32'(k), 4'b0001);
      if (k == 16) checkOutput("warm_ready_low", 32'(ready), 32'h0);
      if (k == 17) begin
        checkOutput("warm_ready_high", 32'(ready), 32'h1);
        checkOutput("warm_no_gnt",     32'(gnt),   32'h0);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h1000_0012, 4'b0001);
    checkOutput("first_gnt",    32'(gnt),    32'h1);
    checkOutput("first_rand",   rand_out,    32'h1000_0012);
    checkOutput("first_served", 32'(served), 32'h1);

    // Round robin with all requesters active; pointer sits at 0 after the first grant.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h2000_0001 + 32'(k), 4'b1111);
      checkOutput("rr_gnt",    32'(gnt),    32'(exp_gnt2[k]));
      checkOutput("rr_rand",   rand_out,    32'h2000_0001 + 32'(k));
      checkOutput("rr_served", 32'(served), 32'(k + 2));
    end

    // Sparse requests with gen_valid toggling.
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k % 2) == 0, 1'b0, 32'h3000_0001 + 32'(k), 4'b1010);
      checkOutput("toggle_gnt",    32'(gnt),    32'(exp_gnt3[k]));
      checkOutput("toggle_rand",   rand_out,    exp_rnd3[k]);
      checkOutput("toggle_served", 32'(served), 32'(exp_srv3[k]));
    end

    // Error beats a pending grant and is sticky.
    applyStimulus(1'b1, 1'b1, 32'h4000_0001, 4'b1111);
    checkOutput("err_gnt",    32'(gnt),    32'h0);
    checkOutput("err_fault",  32'(fault),  32'h1);
    checkOutput("err_ready",  32'(ready),  32'h0);
    checkOutput("err_served", 32'(served), 32'h7);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h4000_0002 + 32'(k), 4'b1111);
      checkOutput("sticky_fault", 32'(fault), 32'h1);
      checkOutput("sticky_gnt",   32'(gnt),   32'h0);
      checkOutput("sticky_ready", 32'(ready), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fault",  32'(fault),  32'h0);
    checkOutput("rst_rand",   rand_out,    32'h0);
    checkOutput("rst_served", 32'(served), 32'h0);
    #2;
    rst_n = 1'b1;

    // WARMUP=0 instance: first valid word moves straight to SERVE, next word goes to requester 2.
    req0 = 4'b0100;
    applyStimulus(1'b1, 1'b0, 32'h5000_0001, 4'b0000);
    checkOutput("w0_ready", 32'(ready0), 32'h1);
    checkOutput("w0_no_gnt", 32'(gnt0),  32'h0);
    applyStimulus(1'b1, 1'b0, 32'h5000_0002, 4'b0000);
    checkOutput("w0_gnt",    32'(gnt0),    32'h4);
    checkOutput("w0_rand",   rand_out0,    32'h5000_0002);
    checkOutput("w0_served", 32'(served0), 32'h1);
    req0 = 4'b0000;

    // Served counter wrap after a fresh start-up.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) applyStimulus(1'b1, 1'b0, 32'h6000_0000 + 32'(k), 4'b0001);
    for (int k = 0; k < 65535; k++) applyStimulus(1'b1, 1'b0, 32'h7000_0000 + 32'(k), 4'b0001);
    checkOutput("wrap_ffff", 32'(served), 32'hFFFF);
    applyStimulus(1'b1, 1'b0, 32'h8000_0001, 4'b0001);
    checkOutput("wrap_zero", 32'(served), 32'h0);
    checkOutput("wrap_gnt",  32'(gnt),    32'h1);
    applyStimulus(1'b1, 1'b0, 32'h8000_0002, 4'b0001);
    checkOutput("post_wrap_served", 32'(served), 32'h1);
    checkOutput("post_wrap_rand",   rand_out,    32'h8000_0002);

    // Asynchronous reset in the middle of a grant cycle.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_gnt",    32'(gnt),    32'h0);
    checkOutput("async_rand",   rand_out,    32'h0);
    checkOutput("async_served", 32'(served), 32'h0);
    checkOutput("async_ready",  32'(ready),  32'h0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
